// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S slave: word-select encoding and the lock/channel state.
package i2s_pkg;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LEFT     = 2'd1,
        RIGHT    = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser with registered one-clk rise/fall strobes on the synchronised level.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    assign sync = chain[SYNC_STAGES-1];

    // Strobes are registered so that they line up with a full clk of setup on the sync level.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= sync;
            rise  <= sync & ~prev;
            fall  <= ~sync & prev;
        end
    end

endmodule

// File: rtl/i2s_slave.sv
// I2S slave endpoint: oversamples sck/ws/sdi on clk, deserialises sdi into left/right words
// and serialises the words captured at tx_req onto sdo.
module i2s_slave
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sdi,
    output logic                  sdo,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid,
    output logic                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

    logic                   sck_s;
    logic                   rise;
    logic                   fall;
    logic [SYNC_STAGES-1:0] ws_chain;
    logic [SYNC_STAGES-1:0] sdi_chain;
    logic                   ws_s;
    logic                   sdi_s;
    logic                   ws_q;

    state_t                 state;
    state_t                 state_next;

    logic [CW-1:0]          bit_cnt;
    logic [CW-1:0]          cnt_after;
    logic [DATA_WIDTH-1:0]  rx_shreg;
    logic [DATA_WIDTH-1:0]  rx_shreg_next;
    logic [DATA_WIDTH-1:0]  hold_left;
    logic                   left_ok;
    logic [DATA_WIDTH-1:0]  tx_shreg;
    logic [DATA_WIDTH-1:0]  shadow_right;

    logic                   ws_edge;
    logic                   do_shift;
    logic                   word_full;
    logic                   commit_end;
    logic                   left_start;
    logic                   right_start;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sck_sync (
        .clk  (clk),
        .arstn(arstn),
        .din  (sck),
        .sync (sck_s),
        .rise (rise),
        .fall (fall)
    );

    assign ws_s  = ws_chain[SYNC_STAGES-1];
    assign sdi_s = sdi_chain[SYNC_STAGES-1];

    // ws and sdi only need a level; they are sampled on the sck rise strobe.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ws_chain  <= '0;
            sdi_chain <= '0;
        end else begin
            ws_chain  <= {ws_chain[SYNC_STAGES-2:0], ws};
            sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], sdi};
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // The bit on a ws-edge rise still belongs to the old channel, so the shift is evaluated
    // before the commit decision and the commit sees the post-shift count and register.
    always_comb begin
        ws_edge       = rise && (ws_s != ws_q);
        do_shift      = rise && (state != UNLOCKED) && (bit_cnt < FULL_CNT);
        cnt_after     = bit_cnt;
        rx_shreg_next = rx_shreg;
        if (do_shift) begin
            cnt_after     = bit_cnt + CW'(1);
            rx_shreg_next = {rx_shreg[DATA_WIDTH-2:0], sdi_s};
        end
        word_full   = (cnt_after == FULL_CNT);
        commit_end  = ws_edge && (state != UNLOCKED);
        left_start  = ws_edge && (ws_s == WS_LEFT);
        right_start = ws_edge && (ws_s == WS_RIGHT) && (state != UNLOCKED);

        state_next = state;
        if (left_start) begin
            state_next = LEFT;
        end else if (right_start) begin
            state_next = RIGHT;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ws_q      <= 1'b0;
            bit_cnt   <= '0;
            rx_shreg  <= '0;
            hold_left <= '0;
            left_ok   <= 1'b0;
            rx_left   <= '0;
            rx_right  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (rise) begin
                ws_q <= ws_s;
            end
            if (do_shift) begin
                rx_shreg <= rx_shreg_next;
            end
            if (ws_edge) begin
                bit_cnt <= '0;
            end else if (do_shift) begin
                bit_cnt <= cnt_after;
            end
            // A right word only reaches the outputs when its left partner was good.
            if (commit_end) begin
                if (!word_full) begin
                    frame_err <= 1'b1;
                    left_ok   <= 1'b0;
                end else if (state == LEFT) begin
                    hold_left <= rx_shreg_next;
                    left_ok   <= 1'b1;
                end else begin
                    left_ok <= 1'b0;
                    if (left_ok) begin
                        rx_left  <= hold_left;
                        rx_right <= rx_shreg_next;
                        rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // The right word is shadowed at left start so both halves of a frame come from one tx_req.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_req       <= 1'b0;
            tx_shreg     <= '0;
            shadow_right <= '0;
            sdo          <= 1'b0;
        end else begin
            tx_req <= 1'b0;
            if (left_start) begin
                tx_req       <= 1'b1;
                shadow_right <= tx_right;
                tx_shreg     <= tx_left;
            end else if (right_start) begin
                tx_shreg <= shadow_right;
            end else if (fall && (state != UNLOCKED)) begin
                sdo      <= tx_shreg[DATA_WIDTH-1];
                tx_shreg <= {tx_shreg[DATA_WIDTH-2:0], 1'b0};
            end
            if (state == UNLOCKED) begin
                sdo <= 1'b0;
            end
        end
    end

endmodule
